// File: rtl/gap_sched_pkg.sv
// Shared constants, FSM encoding and round-robin pick helper for the gap job scheduler.
package gap_sched_pkg;

    localparam int unsigned DW     = 32;
    localparam int unsigned GW     = 6;
    localparam int unsigned KW     = $clog2(DW);
    localparam int unsigned MAXREQ = 8;
    localparam int unsigned PW     = 3;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    typedef struct packed {
        logic          found;
        logic [PW-1:0] idx;
    } pick_t;

    // First valid index at or above ptr, wrapping modulo n.
    function automatic pick_t rr_pick(input logic [MAXREQ-1:0] valid,
                                      input logic [PW-1:0]     ptr,
                                      input int unsigned       n);
        pick_t       r;
        int unsigned j;
        r = '0;
        for (int unsigned i = 0; i < MAXREQ; i++) begin
            j = (32'(ptr) + i) % n;
            if (i < n && !r.found && valid[PW'(j)]) begin
                r.found = 1'b1;
                r.idx   = PW'(j);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/gap_job_sched_if.sv
// Request/response bus between the requesters, the result consumer and gap_job_sched.
interface gap_job_sched_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 32,
    parameter int unsigned GW   = 6,
    parameter int unsigned IDW  = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [GW-1:0]      rsp_gap;
    logic               busy;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_gap, busy
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_gap, busy
    );
endinterface

// File: rtl/gap_scan_core.sv
// Bit-serial longest-bounded-zero-run engine, LSB first.
// GAP_EARLY_EXIT_EN: stop once the remaining shifted word is zero instead of after DW bits.
module gap_scan_core
    import gap_sched_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [DW-1:0] word_i,
    output logic          done_o,
    output logic [GW-1:0] gap_o
);

    logic [DW-1:0] sh_q, sh_d;
    logic [GW-1:0] run_q, run_d;
    logic [GW-1:0] best_q, best_d;
    logic          seen1_q, seen1_d;
    logic          active_q, active_d;
    logic          done_q, done_d;
    logic          last_c;
`ifndef GAP_EARLY_EXIT_EN
    logic [KW-1:0] k_q, k_d;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            sh_q     <= '0;
            run_q    <= '0;
            best_q   <= '0;
            seen1_q  <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
`ifndef GAP_EARLY_EXIT_EN
            k_q      <= '0;
`endif
        end else begin
            sh_q     <= sh_d;
            run_q    <= run_d;
            best_q   <= best_d;
            seen1_q  <= seen1_d;
            active_q <= active_d;
            done_q   <= done_d;
`ifndef GAP_EARLY_EXIT_EN
            k_q      <= k_d;
`endif
        end
    end

`ifdef GAP_EARLY_EXIT_EN
    assign last_c = (sh_q[DW-1:1] == '0);
`else
    assign last_c = (k_q == KW'(DW - 1));
`endif

    // Process one bit per cycle; done pulses once the final bit has been folded into best.
    always_comb begin
        sh_d     = sh_q;
        run_d    = run_q;
        best_d   = best_q;
        seen1_d  = seen1_q;
        active_d = active_q;
        done_d   = 1'b0;
`ifndef GAP_EARLY_EXIT_EN
        k_d      = k_q;
`endif
        if (start_i) begin
            sh_d     = word_i;
            run_d    = '0;
            best_d   = '0;
            seen1_d  = 1'b0;
            active_d = 1'b1;
`ifndef GAP_EARLY_EXIT_EN
            k_d      = '0;
`endif
        end else if (active_q) begin
            sh_d = sh_q >> 1;
`ifndef GAP_EARLY_EXIT_EN
            k_d  = k_q + KW'(1);
`endif
            if (sh_q[0]) begin
                if (seen1_q && (run_q > best_q)) best_d = run_q;
                run_d   = '0;
                seen1_d = 1'b1;
            end else if (seen1_q) begin
                run_d = run_q + GW'(1);
            end
            if (last_c) begin
                active_d = 1'b0;
                done_d   = 1'b1;
            end
        end
    end

    assign done_o = done_q;
    assign gap_o  = best_q;

endmodule

// File: rtl/gap_job_sched.sv
// Round-robin arbiter sharing one gap_scan_core among NREQ requesters; one job in flight.
// GAP_EARLY_EXIT_EN selects the data-dependent-latency engine.
module gap_job_sched
    import gap_sched_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    gap_job_sched_if.slave  bus
);

    logic [1:0]     state_q, state_d;
    logic [IDW-1:0] rr_q, rr_d;
    logic [IDW-1:0] id_q, id_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic           busy_q, busy_d;

    pick_t          pick_c;
    logic [IDW-1:0] sel_c;
    logic [NREQ-1:0] grant_c;
    logic           accept_c;
    logic [DW-1:0]  word_c;
    logic           core_done;
    logic [GW-1:0]  core_gap;

    // Grant is only offered while idle and out of reset.
    always_comb begin
        pick_c  = rr_pick(MAXREQ'(bus.req_valid), PW'(rr_q), NREQ);
        sel_c   = IDW'(pick_c.idx);
        grant_c = '0;
        if (rst && (state_q == IDLE) && pick_c.found) grant_c = NREQ'(1) << sel_c;
    end

    assign accept_c      = |grant_c;
    assign word_c        = bus.req_data[sel_c*DW +: DW];
    assign bus.req_ready = grant_c;

    gap_scan_core u_core (
        .clk     (clk),
        .rst     (rst),
        .start_i (accept_c),
        .word_i  (word_c),
        .done_o  (core_done),
        .gap_o   (core_gap)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            gap_q       <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            gap_q       <= gap_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        gap_d       = gap_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d = SCAN;
                    id_d    = sel_c;
                    rr_d    = IDW'((32'(sel_c) + 32'd1) % NREQ);
                    busy_d  = 1'b1;
                end
            end
            SCAN: begin
                if (core_done) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    gap_d       = core_gap;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_gap   = gap_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_gap_job_sched.sv
// Directed self-checking bench for gap_job_sched (default and GAP_EARLY_EXIT_EN builds).
module tb_gap_job_sched;
    import gap_sched_pkg::*;

    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    gap_job_sched_if #(.NREQ(NREQ), .DW(DW), .GW(GW), .IDW(IDW)) bus ();

    gap_job_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_lat(input int hi);
`ifdef GAP_EARLY_EXIT_EN
        return 2 + hi;
`else
        return 33;
`endif
    endfunction

    task automatic wait_rsp(output int n);
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 200) begin
            tick;
            n++;
        end
    endtask

    task automatic do_reset;
        rst = 1'b0;
        tick;
        rst = 1'b1;
    endtask

    // One job from requester idx, consumer always ready.
    task automatic run_job(input int idx, input logic [31:0] w, input int gap, input int hi, input string tag);
        int n;
        bus.req_data[idx*32 +: 32] = w;
        bus.req_valid = 4'(1) << idx;
        #1;
        chk({tag, ".ready"}, 64'(bus.req_ready), 64'(4'(1) << idx));
        tick;
        bus.req_valid = '0;
        chk({tag, ".busy"}, 64'(bus.busy), 64'd1);
        wait_rsp(n);
        chk({tag, ".lat"}, 64'(n), 64'(exp_lat(hi)));
        chk({tag, ".gap"}, 64'(bus.rsp_gap), 64'(gap));
        chk({tag, ".id"}, 64'(bus.rsp_id), 64'(idx));
        tick;
        chk({tag, ".vdone"}, 64'(bus.rsp_valid), 64'd0);
        chk({tag, ".bdone"}, 64'(bus.busy), 64'd0);
    endtask

    logic [31:0] w3 [4] = '{32'h9, 32'h14, 32'h81, 32'h100001};
    int          g3 [4] = '{2, 1, 6, 19};

    initial begin
        int n;
        int seen;
        bus.req_valid = 4'hF;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b1;

        // reset state
        tick;
        chk("rst.ready", 64'(bus.req_ready), 64'd0);
        tick;
        chk("rst.valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst.busy", 64'(bus.busy), 64'd0);
        chk("rst.gap", 64'(bus.rsp_gap), 64'd0);
        chk("rst.id", 64'(bus.rsp_id), 64'd0);
        bus.req_valid = '0;
        rst = 1'b1;
        tick;

        // single jobs
        run_job(0, 32'h80000001, 30, 31, "t1");
        run_job(0, 32'h00000009, 2, 3, "t2a");
        run_job(1, 32'h00000014, 1, 4, "t2b");
        run_job(2, 32'hFFFFFFFF, 0, 31, "t2c");
        run_job(3, 32'h00000000, 0, 0, "t2d");

        // response backpressure
        bus.rsp_ready = 1'b0;
        bus.req_data[2*32 +: 32] = 32'h14;
        bus.req_data[1*32 +: 32] = 32'h9;
        bus.req_valid = 4'b0100;
        #1;
        tick;
        bus.req_valid = 4'b0010;
        wait_rsp(n);
        chk("t4.gap0", 64'(bus.rsp_gap), 64'd1);
        chk("t4.id0", 64'(bus.rsp_id), 64'd2);
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("t4.hold_v", 64'(bus.rsp_valid), 64'd1);
            chk("t4.hold_g", 64'(bus.rsp_gap), 64'd1);
            chk("t4.hold_id", 64'(bus.rsp_id), 64'd2);
            chk("t4.hold_rdy", 64'(bus.req_ready), 64'd0);
        end
        bus.rsp_ready = 1'b1;
        tick;
        chk("t4.hs_v", 64'(bus.rsp_valid), 64'd0);
        chk("t4.hs_busy", 64'(bus.busy), 64'd0);
        chk("t4.next_rdy", 64'(bus.req_ready), 64'b0010);
        tick;
        bus.req_valid = '0;
        chk("t4.next_busy", 64'(bus.busy), 64'd1);
        chk("t4.next_id", 64'(bus.rsp_id), 64'd1);
        wait_rsp(n);
        chk("t4.next_gap", 64'(bus.rsp_gap), 64'd2);
        tick;

        // round robin with all requesters valid
        do_reset;
        for (int i = 0; i < 4; i++) bus.req_data[i*32 +: 32] = w3[i];
        bus.req_valid = 4'hF;
        #1;
        for (int g = 0; g < 5; g++) begin
            chk("t3.grant", 64'(bus.req_ready), 64'(4'(1) << (g % 4)));
            tick;
            chk("t3.id", 64'(bus.rsp_id), 64'(g % 4));
            wait_rsp(n);
            chk("t3.gap", 64'(bus.rsp_gap), 64'(g3[g % 4]));
            tick;
        end
        bus.req_valid = '0;
        tick;

        // reset in the middle of a scan
        bus.req_data[1*32 +: 32] = 32'h80000001;
        bus.req_data[0*32 +: 32] = 32'h9;
        bus.req_valid = 4'b0010;
        #1;
        tick;
        bus.req_valid = '0;
        chk("t5.busy", 64'(bus.busy), 64'd1);
        for (int i = 0; i < 15; i++) tick;
        rst = 1'b0;
        bus.req_valid = 4'b1001;
        #1;
        chk("t5.rst_rdy", 64'(bus.req_ready), 64'd0);
        tick;
        chk("t5.rst_busy", 64'(bus.busy), 64'd0);
        chk("t5.rst_v", 64'(bus.rsp_valid), 64'd0);
        bus.req_valid = '0;
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (bus.rsp_valid === 1'b1 || bus.busy === 1'b1) seen++;
        end
        chk("t5.no_rsp", 64'(seen), 64'd0);
        bus.req_valid = 4'b1001;
        #1;
        chk("t5.lowest", 64'(bus.req_ready), 64'b0001);
        tick;
        bus.req_valid = '0;
        chk("t5.id", 64'(bus.rsp_id), 64'd0);
        wait_rsp(n);
        chk("t5.gap", 64'(bus.rsp_gap), 64'd2);
        chk("t5.lat", 64'(n), 64'(exp_lat(3)));
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
